// File: rtl/pa_result_requant_pkg.sv
// pa_result_requant_pkg: frame states, int32 limits and the saturating/rounding arithmetic shared by the requant pipeline
package pa_result_requant_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
   localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
   localparam logic signed [63:0] Q31_ROUND = 64'sh4000_0000;
   function automatic logic signed [63:0] sx64(input logic signed [31:0] v);
      return {{32{v[31]}}, v};
   endfunction
   function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
      return (v > sx64(INT32_MAX)) ? INT32_MAX : (v < sx64(INT32_MIN)) ? INT32_MIN : v[31:0];
   endfunction
   function automatic logic signed [31:0] round_shift(input logic signed [31:0] v, input logic [4:0] sh);
      logic signed [63:0] t;
      t = (sx64(v) + (64'sd1 <<< (sh - 5'd1))) >>> sh;
      return (sh == 5'd0) ? v : t[31:0];
   endfunction
endpackage

// File: rtl/pa_result_requant_out_fifo.sv
// pa_out_fifo: synchronous FIFO with occupancy count; push and pop may coincide at any fill level
module pa_out_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic                     valid,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_pop;
   assign valid = count != '0;
   assign do_pop = pop & valid;
   assign dout = valid ? mem[rp] : '0;
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= wp + AW'(push);
         rp <= rp + AW'(do_pop);
         count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/pa_result_requant.sv
// pa_result_requant: drains accumulator results, requantises them to int8 and queues them with their index for the destination writer
module pa_result_requant
   import pa_result_requant_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CNT_W-1:0]    num_results,
   input  logic signed [31:0]  out_offset,
   input  logic signed [7:0]   act_min,
   input  logic signed [7:0]   act_max,
   input  logic                res_rdy,
   output logic                res_acq,
   input  logic signed [31:0]  res_data,
   input  logic signed [31:0]  res_bias,
   input  logic signed [31:0]  res_mult,
   input  logic [4:0]          res_shift,
   output logic                dst_valid,
   input  logic                dst_ready,
   output logic [7:0]          dst_data,
   output logic [CNT_W-1:0]    dst_idx,
   output logic                busy,
   output logic                done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   state_t state;
   logic [CNT_W-1:0] num, issued, popped;
   logic signed [31:0] offset;
   logic signed [7:0] amin, amax;
   logic v1, v2, v3;
   logic signed [31:0] s1_sum, s1_mult, s2_hi;
   logic [4:0] s1_shift, s2_shift;
   logic [CNT_W-1:0] s1_idx, s2_idx, s3_idx;
   logic [7:0] s3_data;
   logic [AW:0] fifo_count;
   logic [AW+1:0] used;
   logic [8+CNT_W-1:0] head;
   logic take, pop;
   logic signed [63:0] prod;
   logic signed [31:0] sum, hi, r, o, lo, up, c;
   // every in-flight result already owns a FIFO slot, so the pipeline never has to stall
   assign used = {1'b0, fifo_count} + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3);
   assign res_acq = state == RUN && issued < num && used < (AW+2)'(FIFO_DEPTH);
   assign take = res_rdy & res_acq;
   assign pop = dst_valid & dst_ready;
   assign busy = state != IDLE;
   assign {dst_data, dst_idx} = head;
   always_comb begin
      sum = sat32(sx64(res_data) + sx64(res_bias));
      prod = sx64(s1_sum) * sx64(s1_mult);
      hi = sat32((prod + Q31_ROUND) >>> 31);
      r = round_shift(s2_hi, s2_shift);
      o = sat32(sx64(r) + sx64(offset));
      lo = {{24{amin[7]}}, amin};
      up = {{24{amax[7]}}, amax};
      c = (o < lo) ? lo : (o > up) ? up : o;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         num <= '0;
         offset <= '0;
         amin <= '0;
         amax <= '0;
         issued <= '0;
         popped <= '0;
         done <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         s1_sum <= '0;
         s1_mult <= '0;
         s1_shift <= '0;
         s1_idx <= '0;
         s2_hi <= '0;
         s2_shift <= '0;
         s2_idx <= '0;
         s3_data <= '0;
         s3_idx <= '0;
      end else begin
         done <= 1'b0;
         issued <= issued + CNT_W'(take);
         popped <= popped + CNT_W'(pop);
         if (state == IDLE && start) begin
            state <= RUN;
            num <= num_results;
            offset <= out_offset;
            amin <= act_min;
            amax <= act_max;
            issued <= '0;
            popped <= '0;
         end
         if (state == RUN && issued == num) state <= DRAIN;
         if (state == DRAIN && popped == num) begin
            state <= IDLE;
            done <= 1'b1;
         end
         v1 <= take;
         v2 <= v1;
         v3 <= v2;
         if (take) begin
            s1_sum <= sum;
            s1_mult <= res_mult;
            s1_shift <= res_shift;
            s1_idx <= issued;
         end
         if (v1) begin
            s2_hi <= hi;
            s2_shift <= s1_shift;
            s2_idx <= s1_idx;
         end
         if (v2) begin
            s3_data <= c[7:0];
            s3_idx <= s2_idx;
         end
      end
   pa_out_fifo #(.DEPTH(FIFO_DEPTH), .W(8 + CNT_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(v3),
      .din({s3_data, s3_idx}),
      .pop(pop),
      .valid(dst_valid),
      .dout(head),
      .count(fifo_count)
   );
endmodule

// File: tb/tb_pa_result_requant.sv
// tb_pa_result_requant: directed frames with a queue scoreboard fed at acceptance and drained at each output pop
module tb_pa_result_requant;
   typedef struct {logic [31:0] d, b, m; logic [4:0] sh;} in_t;
   typedef struct {logic [31:0] idx; logic [7:0] d;} exp_t;
   localparam longint MAXI = 64'sh7fffffff;
   localparam longint MINI = -64'sh80000000;
   logic clk = 1'b0, rst, start, res_rdy, res_acq, dst_valid, dst_ready, busy, done;
   logic [31:0] num_results, dst_idx;
   logic signed [31:0] out_offset, res_data, res_bias, res_mult;
   logic signed [7:0] act_min, act_max;
   logic [4:0] res_shift;
   logic [7:0] dst_data;
   in_t in_q[$];
   exp_t exp_q[$];
   int checks = 0, errors = 0, cyc = 0;
   int frm_acc, frm_pop, done_cnt, done_cyc, start_cyc, first_acc, last_acc, first_pop, last_pop, first_valid;
   bit seen_valid;
   int cfg_off, cfg_min, cfg_max;
   pa_result_requant #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .num_results(num_results), .out_offset(out_offset),
      .act_min(act_min), .act_max(act_max), .res_rdy(res_rdy), .res_acq(res_acq),
      .res_data(res_data), .res_bias(res_bias), .res_mult(res_mult), .res_shift(res_shift),
      .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data), .dst_idx(dst_idx),
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic longint sat(input longint v);
      return (v > MAXI) ? MAXI : (v < MINI) ? MINI : v;
   endfunction
   function automatic logic [7:0] model(input in_t x);
      longint s, h, r, o;
      s = sat(longint'($signed(x.d)) + longint'($signed(x.b)));
      h = sat((s * longint'($signed(x.m)) + (longint'(1) <<< 30)) >>> 31);
      r = (x.sh == 0) ? h : (h + (longint'(1) <<< (x.sh - 1))) >>> x.sh;
      o = sat(r + cfg_off);
      o = (o < cfg_min) ? cfg_min : (o > cfg_max) ? cfg_max : o;
      return o[7:0];
   endfunction
   task automatic drive();
      res_rdy = in_q.size() != 0;
      if (in_q.size() != 0) begin
         res_data = in_q[0].d;
         res_bias = in_q[0].b;
         res_mult = in_q[0].m;
         res_shift = in_q[0].sh;
      end
   endtask
   task automatic tick();
      bit acc_now;
      exp_t e;
      @(negedge clk);
      cyc++;
      acc_now = res_rdy && res_acq && in_q.size() != 0;
      if (acc_now) begin
         exp_q.push_back('{idx: frm_acc, d: model(in_q[0])});
         if (frm_acc == 0) first_acc = cyc;
         last_acc = cyc;
         frm_acc++;
      end
      if (dst_valid && !seen_valid) begin
         seen_valid = 1;
         first_valid = cyc;
      end
      if (dst_valid && dst_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("dst_data", dst_data, e.d);
            chk("dst_idx", dst_idx, e.idx);
         end
         if (frm_pop == 0) first_pop = cyc;
         last_pop = cyc;
         frm_pop++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc_now) void'(in_q.pop_front());
      drive();
   endtask
   task automatic start_frame(input int n, input int off, input int mn, input int mx);
      num_results = n;
      out_offset = off;
      act_min = 8'(mn);
      act_max = 8'(mx);
      cfg_off = off;
      cfg_min = mn;
      cfg_max = mx;
      frm_acc = 0;
      frm_pop = 0;
      done_cnt = 0;
      seen_valid = 0;
      start = 1;
      start_cyc = cyc + 1;
      tick();
      start = 0;
   endtask
   task automatic end_frame(input int n);
      int k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      tick();
      chk("frame_idle", busy, 0);
      chk("done_pulses", done_cnt, 1);
      chk("pop_count", frm_pop, n);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask
   task automatic fill(input int n);
      in_t x;
      for (int i = 0; i < n; i++) begin
         x.d = 32'($signed($urandom) >>> $urandom_range(0, 24));
         x.b = 32'($urandom_range(0, 4000)) - 32'd2000;
         x.m = $urandom;
         x.sh = 5'($urandom_range(0, 31));
         in_q.push_back(x);
      end
   endtask
   initial begin
      int k;
      rst = 1; start = 0; num_results = 0; out_offset = 0; act_min = 0; act_max = 0;
      res_rdy = 0; res_data = 0; res_bias = 0; res_mult = 0; res_shift = 0; dst_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res_acq", res_acq, 0);
      chk("rst_dst_valid", dst_valid, 0);
      chk("rst_dst_data", dst_data, 0);
      chk("rst_dst_idx", dst_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 0;
      tick();
      dst_ready = 1;
      in_q.push_back('{32'd1000, 32'd24, 32'h40000000, 5'd2});
      start_frame(1, -128, -128, 127);
      end_frame(1);
      chk("latency", first_valid - last_acc, 4);
      in_q.push_back('{-32'sd3, 32'd0, 32'h40000000, 5'd0});
      in_q.push_back('{32'd100000, 32'd0, 32'h7fffffff, 5'd0});
      start_frame(2, 0, -128, 127);
      end_frame(2);
      in_q.push_back('{32'h7ffffff0, 32'h100, 32'h7fffffff, 5'd31});
      in_q.push_back('{32'h80000000, 32'd0, 32'h80000000, 5'd24});
      start_frame(2, 0, -128, 127);
      end_frame(2);
      start_frame(0, 0, -128, 127);
      k = 0;
      while (done_cnt == 0 && k < 10) begin
         tick();
         k++;
      end
      chk("zero_done_delay", done_cyc - start_cyc, 3);
      chk("zero_idle", busy, 0);
      dst_ready = 0;
      fill(16);
      start_frame(16, -3, -128, 127);
      repeat (20) tick();
      chk("bp_accepted", frm_acc, 8);
      chk("bp_res_acq", res_acq, 0);
      chk("bp_dst_valid", dst_valid, 1);
      dst_ready = 1;
      end_frame(16);
      fill(17);
      start_frame(16, 5, -20, 100);
      num_results = 3;
      out_offset = 77;
      act_min = 0;
      act_max = 1;
      start = 1;
      tick();
      start = 0;
      k = 0;
      while (frm_acc < 16 && k < 100) begin
         tick();
         k++;
      end
      chk("tp_acq_after_last", res_acq, 0);
      chk("tp_busy", busy, 1);
      chk("tp_accept_span", last_acc - first_acc, 15);
      end_frame(16);
      chk("tp_output_span", last_pop - first_pop, 15);
      in_q.delete();
      drive();
      dst_ready = 0;
      fill(10);
      start_frame(10, 0, -128, 127);
      k = 0;
      while (frm_acc < 5 && k < 50) begin
         tick();
         k++;
      end
      chk("rr_accepted", frm_acc, 5);
      rst = 1;
      #1;
      chk("rr_dst_valid", dst_valid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_res_acq", res_acq, 0);
      exp_q.delete();
      in_q.delete();
      drive();
      tick();
      rst = 0;
      tick();
      dst_ready = 1;
      fill(2);
      start_frame(2, -7, -50, 50);
      end_frame(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
